branch_resolve_ctrl: RTL

- Sequencer wrapped around the combinational branch unit.
- Accepts one branch at a time from issue, registers its operands and drives them into the branch unit for one evaluation cycle.
- Compares the result against the front-end prediction, then either retires quietly, issues a fetch redirect plus pipeline flush, or raises a misaligned-target trap.
- Keeps saturating branch and mispredict counters for perf monitoring.

---
 rtl/branch_resolve_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - sequencer around the combinational branch unit: evaluate, redirect, trap, flush, perf counters
module branch_resolve_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_req_valid,
    output logic             io_req_ready,
    input  logic [XLEN-1:0]  io_req_rs1,
    input  logic [XLEN-1:0]  io_req_rs2,
    input  logic [XLEN-1:0]  io_req_pc,
    input  logic [11:0]      io_req_imm,
    input  logic [2:0]       io_req_branchOp,
    input  logic             io_req_predTaken,
    input  logic [XLEN-1:0]  io_req_predTarget,
    output logic [XLEN-1:0]  io_bu_rs1,
    output logic [XLEN-1:0]  io_bu_rs2,
    output logic [XLEN-1:0]  io_bu_pc,
    output logic [11:0]      io_bu_imm,
    output logic [2:0]       io_bu_branchOp,
    output logic             io_bu_valid,
    input  logic             io_bu_taken,
    input  logic [XLEN-1:0]  io_bu_target,
    input  logic [XLEN-1:0]  io_bu_nextPc,
    input  logic             io_bu_misaligned,
    output logic             io_redir_valid,
    input  logic             io_redir_ready,
    output logic [XLEN-1:0]  io_redir_pc,
    output logic             io_trap_valid,
    input  logic             io_trap_ack,
    output logic [XLEN-1:0]  io_trap_pc,
    output logic [XLEN-1:0]  io_trap_tval,
    output logic             io_flush,
    output logic             io_resolve,
    output logic             io_busy,
    input  logic             io_cnt_clear,
    output logic [CNT_W-1:0] io_cnt_branches,
    output logic [CNT_W-1:0] io_cnt_mispredicts
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_REDIRECT,
        S_TRAP,
        S_FLUSH
    } state_t;

    state_t            state_q;
    logic              ready_q;
    logic [XLEN-1:0]   rs1_q, rs2_q, pc_q, pred_target_q;
    logic [11:0]       imm_q;
    logic [2:0]        op_q;
    logic              pred_taken_q;
    logic [XLEN-1:0]   redir_pc_q, tval_q;
    logic [3:0]        flush_cnt_q;
    logic [CNT_W-1:0]  cnt_br_q, cnt_mp_q;

    logic              in_eval;
    logic              mispredict;
    logic [XLEN-1:0]   tval_calc;

    assign in_eval    = (state_q == S_EVAL);
    assign mispredict = (io_bu_taken != pred_taken_q) |
                        (io_bu_taken & (io_bu_target != pred_target_q));
    assign tval_calc  = pc_q + {{(XLEN-12){imm_q[11]}}, imm_q};

    assign io_req_ready   = ready_q;
    assign io_busy        = (state_q != S_IDLE);
    assign io_bu_valid    = in_eval;
    assign io_bu_rs1      = in_eval ? rs1_q : '0;
    assign io_bu_rs2      = in_eval ? rs2_q : '0;
    assign io_bu_pc       = in_eval ? pc_q : '0;
    assign io_bu_imm      = in_eval ? imm_q : '0;
    assign io_bu_branchOp = in_eval ? op_q : '0;
    assign io_resolve     = in_eval & ~io_bu_misaligned & ~mispredict;
    assign io_redir_valid = (state_q == S_REDIRECT);
    assign io_redir_pc    = io_redir_valid ? redir_pc_q : '0;
    assign io_trap_valid  = (state_q == S_TRAP);
    assign io_trap_pc     = io_trap_valid ? pc_q : '0;
    assign io_trap_tval   = io_trap_valid ? tval_q : '0;
    assign io_flush       = (state_q == S_FLUSH);
    assign io_cnt_branches    = cnt_br_q;
    assign io_cnt_mispredicts = cnt_mp_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            ready_q       <= 1'b0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            pc_q          <= '0;
            imm_q         <= '0;
            op_q          <= '0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            redir_pc_q    <= '0;
            tval_q        <= '0;
            flush_cnt_q   <= '0;
            cnt_br_q      <= '0;
            cnt_mp_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (io_req_valid && ready_q) begin
                        rs1_q         <= io_req_rs1;
                        rs2_q         <= io_req_rs2;
                        pc_q          <= io_req_pc;
                        imm_q         <= io_req_imm;
                        op_q          <= io_req_branchOp;
                        pred_taken_q  <= io_req_predTaken;
                        pred_target_q <= io_req_predTarget;
                        ready_q       <= 1'b0;
                        state_q       <= S_EVAL;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_EVAL: begin
                    redir_pc_q <= io_bu_nextPc;
                    tval_q     <= tval_calc;
                    // Misaligned target outranks any prediction outcome.
                    if (io_bu_misaligned) begin
                        state_q <= S_TRAP;
                    end else if (mispredict) begin
                        state_q <= S_REDIRECT;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_REDIRECT: begin
                    if (io_redir_ready) begin
                        flush_cnt_q <= 4'(FLUSH_CYCLES);
                        state_q     <= S_FLUSH;
                    end
                end
                S_TRAP: begin
                    if (io_trap_ack) begin
                        flush_cnt_q <= 4'(FLUSH_CYCLES);
                        state_q     <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt_q <= 4'd1) begin
                        flush_cnt_q <= '0;
                        ready_q     <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 4'd1;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase

            // Clear wins over a same-cycle increment; both counters saturate.
            if (io_cnt_clear) begin
                cnt_br_q <= '0;
                cnt_mp_q <= '0;
            end else if (in_eval) begin
                if (!(&cnt_br_q))
                    cnt_br_q <= cnt_br_q + CNT_W'(1);
                if (!io_bu_misaligned && mispredict && !(&cnt_mp_q))
                    cnt_mp_q <= cnt_mp_q + CNT_W'(1);
            end
        end
    end

endmodule
